// File: rtl/sd_rd_arbiter.sv
// Round-robin arbiter sharing one SD sector reader between the two floppy read requesters.
// Grants one drive at a time, latches its LBA and routes the reader handshake back to it.
module sd_rd_arbiter #(
    parameter int LBA_W = 32,
    parameter int TMO_W = 20
) (
    input  logic             clk_32,
    input  logic             reset,
    input  logic [1:0]       req_rd,
    input  logic [LBA_W-1:0] req_lba0,
    input  logic [LBA_W-1:0] req_lba1,
    output logic [1:0]       req_ack,
    output logic [1:0]       req_strobe,
    output logic [1:0]       req_done,
    output logic [1:0]       req_err,
    output logic             rstart,
    output logic [LBA_W-1:0] rsector,
    input  logic             rbusy,
    input  logic             rdone,
    input  logic             outen,
    output logic [1:0]       grant
);

    typedef enum logic [1:0] {IDLE, START, BUSY, RELEASE} state_t;

    // Last START cycle before abort: rstart stays high for 2^TMO_W-1 cycles in total.
    localparam logic [TMO_W-1:0] TMO_LAST = {{(TMO_W-1){1'b1}}, 1'b0};

    state_t             state_q;
    logic               owner_q;
    logic               rr_ptr_q;
    logic [1:0]         grant_q;
    logic [1:0]         ack_q;
    logic [1:0]         done_q;
    logic [1:0]         err_q;
    logic               rstart_q;
    logic [LBA_W-1:0]   rsector_q;
    logic [TMO_W-1:0]   cnt_q;

    logic               owner_d;
    logic [TMO_W-1:0]   cnt_d;

    // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
    always_comb begin
        owner_d = (req_rd == 2'b11) ? rr_ptr_q : req_rd[1];
        cnt_d   = cnt_q + 1'b1;
    end

    // NOTE: sequential state uses non-blocking assignments only, so all registers
    // update together at the edge regardless of statement order.
    always_ff @(posedge clk_32 or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            owner_q   <= 1'b0;
            rr_ptr_q  <= 1'b0;
            grant_q   <= 2'b00;
            ack_q     <= 2'b00;
            done_q    <= 2'b00;
            err_q     <= 2'b00;
            rstart_q  <= 1'b0;
            rsector_q <= '0;
            cnt_q     <= '0;
        end else begin
            done_q <= 2'b00;
            err_q  <= 2'b00;
            case (state_q)
                IDLE: begin
                    if (|req_rd) begin
                        owner_q   <= owner_d;
                        grant_q   <= owner_d ? 2'b10 : 2'b01;
                        ack_q     <= owner_d ? 2'b10 : 2'b01;
                        rsector_q <= owner_d ? req_lba1 : req_lba0;
                        rr_ptr_q  <= ~owner_d;
                        rstart_q  <= 1'b1;
                        cnt_q     <= '0;
                        state_q   <= START;
                    end
                end
                START: begin
                    if (rbusy) begin
                        rstart_q <= 1'b0;
                        cnt_q    <= '0;
                        state_q  <= BUSY;
                    end else if (cnt_q == TMO_LAST) begin
                        rstart_q <= 1'b0;
                        ack_q    <= 2'b00;
                        done_q   <= grant_q;
                        err_q    <= grant_q;
                        cnt_q    <= '0;
                        state_q  <= RELEASE;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                BUSY: begin
                    if (rdone || !rbusy) begin
                        ack_q   <= 2'b00;
                        done_q  <= grant_q;
                        state_q <= RELEASE;
                    end
                end
                RELEASE: begin
                    // Wait for the owner to drop its level so a held request never retriggers.
                    if (!req_rd[owner_q]) begin
                        grant_q <= 2'b00;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign req_strobe = (state_q == BUSY) ? (grant_q & {2{outen}}) : 2'b00;
    assign req_ack    = ack_q;
    assign req_done   = done_q;
    assign req_err    = err_q;
    assign rstart     = rstart_q;
    assign rsector    = rsector_q;
    assign grant      = grant_q;

endmodule

// File: tb/tb_sd_rd_arbiter.sv
// Directed self-checking bench for sd_rd_arbiter, built with a short start timeout.
module tb_sd_rd_arbiter;

    localparam int LBA_W = 32;
    localparam int TMO_W = 4;

    logic             clk_32 = 1'b0;
    logic             reset;
    logic [1:0]       req_rd;
    logic [LBA_W-1:0] req_lba0, req_lba1;
    logic [1:0]       req_ack, req_strobe, req_done, req_err, grant;
    logic             rstart;
    logic [LBA_W-1:0] rsector;
    logic             rbusy, rdone, outen;

    int tests = 0;
    int fails = 0;
    int s0, s1, hi;

    sd_rd_arbiter #(.LBA_W(LBA_W), .TMO_W(TMO_W)) dut (
        .clk_32(clk_32), .reset(reset), .req_rd(req_rd),
        .req_lba0(req_lba0), .req_lba1(req_lba1),
        .req_ack(req_ack), .req_strobe(req_strobe), .req_done(req_done),
        .req_err(req_err), .rstart(rstart), .rsector(rsector),
        .rbusy(rbusy), .rdone(rdone), .outen(outen), .grant(grant)
    );

    always #5 clk_32 = ~clk_32;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests++;
        assert (observed === expected)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk_32);
            #1;
        end
    endtask

    initial begin
        reset = 1'b1; req_rd = 2'b00; req_lba0 = '0; req_lba1 = '0;
        rbusy = 1'b0; rdone = 1'b0; outen = 1'b0;
        #3;
        check("rst_rstart", 32'(rstart), 32'd0);
        check("rst_rsector", rsector, 32'd0);
        check("rst_ack", 32'(req_ack), 32'd0);
        check("rst_grant", 32'(grant), 32'd0);
        check("rst_done_err", 32'({req_done, req_err}), 32'd0);
        tick();
        reset = 1'b0;

        // Single request from drive 0
        req_rd = 2'b01; req_lba0 = 32'h0000_0123; req_lba1 = 32'hDEAD_BEEF;
        tick();
        check("single_rstart", 32'(rstart), 32'd1);
        check("single_rsector", rsector, 32'h123);
        check("single_grant", 32'(grant), 32'b01);
        check("single_ack", 32'(req_ack), 32'b01);
        outen = 1'b1; #1;
        check("start_outen_dropped", 32'(req_strobe), 32'b00);
        outen = 1'b0;
        tick(2);
        rbusy = 1'b1;
        tick();
        check("busy_rstart_low", 32'(rstart), 32'd0);
        s0 = 0; s1 = 0;
        for (int i = 0; i < 512; i++) begin
            outen = 1'b1; #1;
            s0 += int'(req_strobe[0]); s1 += int'(req_strobe[1]);
            outen = 1'b0; #1;
            s0 += int'(req_strobe[0]); s1 += int'(req_strobe[1]);
            tick();
        end
        check("strobe_bit0_count", s0, 32'd512);
        check("strobe_bit1_count", s1, 32'd0);
        rdone = 1'b1;
        tick();
        check("single_done", 32'(req_done), 32'b01);
        check("single_ack_off", 32'(req_ack), 32'b00);
        check("single_err_none", 32'(req_err), 32'b00);
        rdone = 1'b0; rbusy = 1'b0;
        outen = 1'b1; #1;
        check("release_outen_dropped", 32'(req_strobe), 32'b00);
        outen = 1'b0;
        tick();
        check("done_one_cycle", 32'(req_done), 32'b00);
        check("release_grant_held", 32'(grant), 32'b01);
        req_rd = 2'b00;
        tick();
        check("single_grant_off", 32'(grant), 32'b00);

        // Simultaneous requests after reset: drive 0 first, then drive 1
        reset = 1'b1; #2; reset = 1'b0;
        req_rd = 2'b11; req_lba0 = 32'h0000_0AAA; req_lba1 = 32'h0000_0BBB;
        tick();
        check("sim1_grant", 32'(grant), 32'b01);
        check("sim1_rsector", rsector, 32'hAAA);
        rbusy = 1'b1;
        tick();
        rdone = 1'b1;
        tick();
        check("sim1_done", 32'(req_done), 32'b01);
        rdone = 1'b0; rbusy = 1'b0; req_rd = 2'b10;
        tick();
        check("sim1_released", 32'(grant), 32'b00);
        tick();
        check("sim2_grant", 32'(grant), 32'b10);
        check("sim2_rsector", rsector, 32'hBBB);
        check("sim2_rstart", 32'(rstart), 32'd1);
        rbusy = 1'b1;
        tick();
        rbusy = 1'b0;
        tick();
        check("sim2_done_on_busy_fall", 32'(req_done), 32'b10);
        check("sim2_ack_off", 32'(req_ack), 32'b00);

        // Held request: no retrigger while req_rd[1] stays high
        tick(3);
        check("held_no_rstart", 32'(rstart), 32'd0);
        check("held_grant", 32'(grant), 32'b10);
        req_rd = 2'b00;
        tick();
        check("held_released", 32'(grant), 32'b00);
        req_rd = 2'b11;
        tick();
        check("rr_back_to_0", 32'(grant), 32'b01);
        check("rr_back_rsector", rsector, 32'hAAA);
        rbusy = 1'b1;
        tick();
        rbusy = 1'b0; rdone = 1'b1;
        tick();
        check("rr_done0", 32'(req_done), 32'b01);
        rdone = 1'b0; req_rd = 2'b10;
        tick(2);
        check("rerequest_grant1", 32'(grant), 32'b10);
        check("rerequest_rstart", 32'(rstart), 32'd1);
        rbusy = 1'b1;
        tick();
        rdone = 1'b1;
        tick();
        rdone = 1'b0; rbusy = 1'b0; req_rd = 2'b00;
        tick(2);

        // Start timeout: rbusy never rises
        req_rd = 2'b01; req_lba0 = 32'h0000_0CCC;
        tick();
        hi = int'(rstart);
        for (int k = 0; k < 40; k++) begin
            tick();
            if (rstart) hi++;
            else break;
        end
        check("tmo_rstart_cycles", hi, 32'd15);
        check("tmo_done", 32'(req_done), 32'b01);
        check("tmo_err", 32'(req_err), 32'b01);
        check("tmo_ack_off", 32'(req_ack), 32'b00);
        tick();
        check("tmo_pulse_one_cycle", 32'({req_done, req_err}), 32'd0);
        req_rd = 2'b00;
        tick(2);

        // Requester drops during BUSY: transfer still completes to drive 0
        req_rd = 2'b01;
        tick();
        rbusy = 1'b1;
        tick();
        req_rd = 2'b00;
        outen = 1'b1; #1;
        check("drop_strobe", 32'(req_strobe), 32'b01);
        outen = 1'b0;
        tick();
        rdone = 1'b1;
        tick();
        check("drop_done", 32'(req_done), 32'b01);
        rdone = 1'b0; rbusy = 1'b0;
        tick();
        check("drop_idle_grant", 32'(grant), 32'b00);
        check("drop_done_cleared", 32'(req_done), 32'b00);

        // Reset while BUSY clears everything at once; stale rdone is ignored
        req_rd = 2'b10; req_lba1 = 32'h0000_0DDD;
        tick();
        rbusy = 1'b1;
        tick();
        check("rstbusy_ack", 32'(req_ack), 32'b10);
        reset = 1'b1; #1;
        check("rstbusy_ack_off", 32'(req_ack), 32'b00);
        check("rstbusy_grant_off", 32'(grant), 32'b00);
        check("rstbusy_rsector", rsector, 32'd0);
        outen = 1'b1; #1;
        check("rstbusy_strobe", 32'(req_strobe), 32'b00);
        outen = 1'b0;
        reset = 1'b0; req_rd = 2'b00; rdone = 1'b1;
        tick();
        check("post_rst_no_done", 32'(req_done), 32'b00);
        check("post_rst_idle", 32'(grant), 32'b00);
        rdone = 1'b0; rbusy = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
